// File: rtl/button_conditioner.sv
// Raw push-button conditioner: synchroniser, debounce FSM, press/release pulses.
// Optional auto-repeat on held press is compiled in with `define BTN_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic          INVERT   = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic          pressed_n;
    logic          sync1_q;
    logic          sync2_q;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;
    logic          release_q;
    logic          release_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic arm_q;
    logic arm_d;
    logic first_q;
    logic first_d;
`endif

    assign pressed_n = btn_raw ^ INVERT;

    // Two-flop synchroniser on the normalised (1 = pressed) level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pressed_n;
            sync2_q <= sync1_q;
        end
    end

    // State, shared debounce/repeat counter and registered pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RELEASED;
            cnt_q     <= CNT_ZERO;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            arm_q     <= 1'b0;
            first_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
            arm_q     <= arm_d;
            first_q   <= first_d;
`endif
        end
    end

    // Next-state: debounce timing, plus repeat timing while held
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        arm_d     = arm_q;
        first_d   = first_q;
`endif
        unique case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                    press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    arm_d   = 1'b1;
                    first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
                    arm_d   = 1'b0;
                    first_d = 1'b1;
`endif
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (arm_q) begin
                    if (cnt_q == (first_q ? RD_LAST : RP_LAST)) begin
                        cnt_d   = CNT_ZERO;
                        press_d = 1'b1;
                        first_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`endif
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = CNT_ZERO;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs decoded from the stable/timing state
    always_comb begin
        btn_level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
        busy      = (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
